// File: rtl/fx1_sched.sv
// FX1 issue scheduler: round-robin grant of two requesters, hazard blocking, fixed-latency writeback tracking.
// Latency: zero-cycle combinational grant, writeback LAT cycles after issue; backpressure via ready held low on hazard, lost arbitration or flush.
module fx1_sched #(
    parameter int LAT = 2,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [OPW-1:0] req0_op,
    input  logic [6:0]     req0_ra,
    input  logic [6:0]     req0_rb,
    input  logic [6:0]     req0_rt,
    input  logic           req0_rb_used,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [OPW-1:0] req1_op,
    input  logic [6:0]     req1_ra,
    input  logic [6:0]     req1_rb,
    input  logic [6:0]     req1_rt,
    input  logic           req1_rb_used,
    input  logic           flush,
    output logic           iss_valid,
    output logic [OPW-1:0] iss_op,
    output logic [6:0]     iss_ra,
    output logic [6:0]     iss_rb,
    output logic [6:0]     iss_rt,
    output logic           iss_src,
    output logic           wb_valid,
    output logic [6:0]     wb_rt,
    output logic           wb_src,
    output logic           busy,
    output logic [15:0]    hz_stall_cnt
);

    logic [LAT:1] st_vld;
    logic [LAT:1] st_src;
    logic [6:0]   st_rt [1:LAT];
    logic         last_gnt;
    logic         hz0, hz1, elig0, elig1, gnt0, gnt1, gnt;

    always_comb begin
        hz0 = 1'b0;
        hz1 = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            if (st_vld[k]) begin
                if (st_rt[k] == req0_ra || st_rt[k] == req0_rt ||
                    (req0_rb_used && st_rt[k] == req0_rb))
                    hz0 = 1'b1;
                if (st_rt[k] == req1_ra || st_rt[k] == req1_rt ||
                    (req1_rb_used && st_rt[k] == req1_rb))
                    hz1 = 1'b1;
            end
        end
        hz0 = hz0 & req0_valid;
        hz1 = hz1 & req1_valid;
    end

    // Grants are gated by rst_n so every output reads 0 while reset is held.
    assign elig0 = req0_valid && !hz0 && !flush && rst_n;
    assign elig1 = req1_valid && !hz1 && !flush && rst_n;
    assign gnt0  = elig0 && (!elig1 || last_gnt);
    assign gnt1  = elig1 && (!elig0 || !last_gnt);
    assign gnt   = gnt0 | gnt1;

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign iss_valid  = gnt;
    assign iss_src    = gnt1;
    assign iss_op     = gnt0 ? req0_op : (gnt1 ? req1_op : '0);
    assign iss_ra     = gnt0 ? req0_ra : (gnt1 ? req1_ra : '0);
    assign iss_rb     = gnt0 ? req0_rb : (gnt1 ? req1_rb : '0);
    assign iss_rt     = gnt0 ? req0_rt : (gnt1 ? req1_rt : '0);

    assign wb_valid = st_vld[LAT];
    assign wb_rt    = st_rt[LAT];
    assign wb_src   = st_src[LAT];
    assign busy     = |st_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_vld       <= '0;
            st_src       <= '0;
            for (int k = 1; k <= LAT; k++) st_rt[k] <= '0;
            last_gnt     <= 1'b1;
            hz_stall_cnt <= '0;
        end else begin
            st_vld[1] <= gnt && !flush;
            st_src[1] <= gnt1;
            st_rt[1]  <= gnt ? iss_rt : '0;
            for (int k = 2; k <= LAT; k++) begin
                st_vld[k] <= st_vld[k-1] && !flush;
                st_src[k] <= st_src[k-1];
                st_rt[k]  <= st_rt[k-1];
            end
            if (gnt) last_gnt <= gnt1;
            if ((hz0 || hz1) && !gnt && !flush && hz_stall_cnt != 16'hFFFF)
                hz_stall_cnt <= hz_stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_fx1_sched.sv
// Directed bench for fx1_sched (LAT=2): independent issue, RAW stall, round-robin, bypass, rb_used, flush, reset.
module tb_fx1_sched;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req0_rb_used;
    logic [3:0] req0_op;
    logic [6:0] req0_ra, req0_rb, req0_rt;
    logic       req1_valid, req1_ready, req1_rb_used;
    logic [3:0] req1_op;
    logic [6:0] req1_ra, req1_rb, req1_rt;
    logic       flush;
    logic       iss_valid, iss_src, wb_valid, wb_src, busy;
    logic [3:0] iss_op;
    logic [6:0] iss_ra, iss_rb, iss_rt, wb_rt;
    logic [15:0] hz_stall_cnt;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fx1_sched #(.LAT(2), .OPW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_ra(req0_ra), .req0_rb(req0_rb), .req0_rt(req0_rt), .req0_rb_used(req0_rb_used),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_ra(req1_ra), .req1_rb(req1_rb), .req1_rt(req1_rt), .req1_rb_used(req1_rb_used),
        .flush(flush),
        .iss_valid(iss_valid), .iss_op(iss_op), .iss_ra(iss_ra), .iss_rb(iss_rb),
        .iss_rt(iss_rt), .iss_src(iss_src),
        .wb_valid(wb_valid), .wb_rt(wb_rt), .wb_src(wb_src),
        .busy(busy), .hz_stall_cnt(hz_stall_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set0(input logic v, input logic [3:0] op, input logic [6:0] ra,
                        input logic [6:0] rb, input logic [6:0] rt, input logic rbu);
        req0_valid = v; req0_op = op; req0_ra = ra; req0_rb = rb; req0_rt = rt; req0_rb_used = rbu;
    endtask

    task automatic set1(input logic v, input logic [3:0] op, input logic [6:0] ra,
                        input logic [6:0] rb, input logic [6:0] rt, input logic rbu);
        req1_valid = v; req1_op = op; req1_ra = ra; req1_rb = rb; req1_rt = rt; req1_rb_used = rbu;
    endtask

    // Advance to just after the next rising edge, then let combinational outputs settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        set0(0, 0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic exp_src [4];
        exp_src[0] = 0; exp_src[1] = 1; exp_src[2] = 0; exp_src[3] = 1;
        rst_n = 1'b0;
        flush = 1'b0;
        set0(1, 4'h3, 1, 2, 5, 1);
        set1(0, 0, 0, 0, 0, 0);
        #3;
        check_eq("rst_ready0", req0_ready, 0);
        check_eq("rst_iss_valid", iss_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_wb_valid", wb_valid, 0);
        check_eq("rst_cnt", hz_stall_cnt, 0);
        step();
        rst_n = 1'b1;
        #1;

        // Independent back-to-back ops
        check_eq("ind_c0_iss", iss_valid, 1);
        check_eq("ind_c0_op", iss_op, 4'h3);
        check_eq("ind_c0_rt", iss_rt, 5);
        step();
        set0(1, 4'h3, 1, 2, 6, 1);
        #1;
        check_eq("ind_c1_iss", iss_valid, 1);
        step();
        set0(0, 0, 0, 0, 0, 0);
        #1;
        check_eq("ind_c2_wb", wb_valid, 1);
        check_eq("ind_c2_wbrt", wb_rt, 5);
        check_eq("ind_c2_busy", busy, 1);
        step();
        check_eq("ind_c3_wb", wb_valid, 1);
        check_eq("ind_c3_wbrt", wb_rt, 6);
        step();
        check_eq("ind_c4_busy", busy, 0);
        check_eq("ind_c4_wb", wb_valid, 0);

        // RAW stall
        set0(1, 4'h1, 1, 2, 10, 1);
        #1;
        check_eq("raw_c0_ready", req0_ready, 1);
        step();
        set0(1, 4'h1, 10, 2, 11, 1);
        #1;
        check_eq("raw_c1_ready", req0_ready, 0);
        step();
        check_eq("raw_c2_ready", req0_ready, 0);
        step();
        check_eq("raw_c3_ready", req0_ready, 1);
        check_eq("raw_c3_cnt", hz_stall_cnt, 2);
        step();
        idle(3);

        // Round-robin from reset
        rst_n = 1'b0;
        #1;
        check_eq("rr_rst_cnt", hz_stall_cnt, 0);
        step();
        rst_n = 1'b1;
        set0(1, 4'h2, 0, 0, 20, 1);
        set1(1, 4'h2, 0, 0, 40, 1);
        #1;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("rr_src%0d", i), iss_src, exp_src[i]);
            check_eq($sformatf("rr_iss%0d", i), iss_valid, 1);
            step();
            if (exp_src[i] == 0) set0(1, 4'h2, 0, 0, 7'(21 + i), 1);
            else                 set1(1, 4'h2, 0, 0, 7'(41 + i), 1);
            #1;
        end
        idle(3);

        // Hazard bypass
        set0(1, 4'h4, 1, 2, 3, 1);
        #1;
        check_eq("byp_c0_ready0", req0_ready, 1);
        step();
        set0(1, 4'h4, 3, 2, 4, 1);
        set1(1, 4'h5, 1, 2, 8, 1);
        #1;
        check_eq("byp_c1_ready0", req0_ready, 0);
        check_eq("byp_c1_ready1", req1_ready, 1);
        check_eq("byp_c1_src", iss_src, 1);
        step();
        set1(1, 4'h5, 1, 2, 9, 1);
        #1;
        check_eq("byp_c2_ready1", req1_ready, 1);
        step();
        set1(1, 4'h5, 1, 2, 12, 1);
        #1;
        check_eq("byp_c3_ready0", req0_ready, 1);
        check_eq("byp_c3_ready1", req1_ready, 0);
        check_eq("byp_c3_src", iss_src, 0);
        check_eq("byp_c3_cnt", hz_stall_cnt, 0);
        step();
        idle(3);

        // rb_used masking
        set0(0, 0, 0, 0, 0, 0);
        set1(1, 4'h6, 1, 2, 7, 1);
        #1;
        check_eq("rbu_c0_ready1", req1_ready, 1);
        step();
        set1(1, 4'h6, 1, 7, 13, 0);
        #1;
        check_eq("rbu0_ready1", req1_ready, 1);
        step();
        set1(1, 4'h6, 1, 7, 14, 1);
        #1;
        check_eq("rbu1_ready1", req1_ready, 0);
        step();
        check_eq("rbu1_late_ready1", req1_ready, 1);
        check_eq("rbu_cnt", hz_stall_cnt, 1);
        check_eq("rbu_wbsrc", wb_src, 1);
        step();
        idle(3);

        // Flush
        set0(1, 4'h7, 1, 2, 15, 1);
        #1;
        check_eq("fl_c0_ready", req0_ready, 1);
        step();
        set0(1, 4'h7, 1, 2, 16, 1);
        #1;
        check_eq("fl_c1_ready", req0_ready, 1);
        step();
        set0(1, 4'h7, 1, 2, 17, 1);
        flush = 1'b1;
        #1;
        check_eq("fl_c2_ready", req0_ready, 0);
        check_eq("fl_c2_iss", iss_valid, 0);
        check_eq("fl_c2_wb", wb_valid, 1);
        check_eq("fl_c2_wbrt", wb_rt, 15);
        step();
        flush = 1'b0;
        set0(0, 0, 0, 0, 0, 0);
        #1;
        check_eq("fl_c3_busy", busy, 0);
        check_eq("fl_c3_wb", wb_valid, 0);

        // Reset mid-pipe
        set0(1, 4'h8, 1, 2, 18, 1);
        step();
        set0(1, 4'h8, 1, 2, 19, 1);
        #1;
        check_eq("mr_pre_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_eq("mr_busy", busy, 0);
        check_eq("mr_ready0", req0_ready, 0);
        check_eq("mr_iss", iss_valid, 0);
        check_eq("mr_issrt", iss_rt, 0);
        check_eq("mr_wb", wb_valid, 0);
        set0(0, 0, 0, 0, 0, 0);
        step();
        rst_n = 1'b1;
        step();
        check_eq("mr_post_wb", wb_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
